// File: rtl/lfsr_code_gen.sv
// Fibonacci-LFSR code word generator: STEPS shifts per requested word, NUM_CODES symbols of CODE_W bits.
// Optional macro LFSR_CODE_GEN_DISTINCT_EN rejects candidate words that contain repeated symbols.
module lfsr_code_gen #(
  parameter int unsigned CODE_W    = 3,
  parameter int unsigned NUM_CODES = 4,
  parameter logic [CODE_W*NUM_CODES-1:0] TAPS = 12'hE08,
  parameter logic [CODE_W*NUM_CODES-1:0] SEED = 12'h13D,
  parameter int unsigned STEPS     = CODE_W*NUM_CODES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          seed_load,
  input  logic [CODE_W*NUM_CODES-1:0]   seed_in,
  input  logic                          req,
  output logic                          ready,
  output logic                          valid,
  output logic [NUM_CODES*CODE_W-1:0]   codes
);

  localparam int unsigned LFSR_W = CODE_W * NUM_CODES;
  localparam int unsigned CNT_W  = $clog2(STEPS + 1);

  generate
    if (STEPS < 1 || STEPS > 255) begin : g_bad_steps
      $error("lfsr_code_gen: STEPS must be in 1..255");
    end
    if (LFSR_W < 2) begin : g_bad_width
      $error("lfsr_code_gen: LFSR width must be at least 2");
    end
    if (SEED == '0) begin : g_bad_seed
      $error("lfsr_code_gen: SEED must be nonzero");
    end
`ifdef LFSR_CODE_GEN_DISTINCT_EN
    if (NUM_CODES > (1 << CODE_W)) begin : g_bad_distinct
      $error("lfsr_code_gen: NUM_CODES exceeds 2**CODE_W, distinct symbols impossible");
    end
`endif
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [LFSR_W-1:0]  lfsr, lfsr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LFSR_W-1:0]  codes_n;
  logic               valid_n;
  logic               fb;
  logic [LFSR_W-1:0]  shifted;
  logic               last_step;
  logic               accept;

`ifdef LFSR_CODE_GEN_DISTINCT_EN
  function automatic logic all_distinct(input logic [LFSR_W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < NUM_CODES; i++) begin
      for (int unsigned j = i + 1; j < NUM_CODES; j++) begin
        if (w[i*CODE_W +: CODE_W] == w[j*CODE_W +: CODE_W]) ok = 1'b0;
      end
    end
    return ok;
  endfunction
`endif

  // An all-zero state can never leave itself, so it is replaced by SEED at the shift edge.
  always_comb begin
    fb      = ^(lfsr & TAPS);
    shifted = (lfsr == '0) ? SEED : {lfsr[LFSR_W-2:0], fb};
  end

  assign last_step = (cnt == CNT_W'(STEPS - 1));

`ifdef LFSR_CODE_GEN_DISTINCT_EN
  assign accept = all_distinct(shifted);
`else
  assign accept = 1'b1;
`endif

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    cnt_n   = cnt;
    codes_n = codes;
    valid_n = 1'b0;
    if (seed_load) begin
      lfsr_n  = (seed_in == '0) ? SEED : seed_in;
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state_n = SHIFT;
            cnt_n   = '0;
          end
        end
        SHIFT: begin
          lfsr_n = shifted;
          if (last_step) begin
            // A rejected candidate simply restarts the block count and keeps shifting.
            cnt_n = '0;
            if (accept) begin
              codes_n = shifted;
              valid_n = 1'b1;
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= SEED;
      cnt   <= '0;
      codes <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      lfsr  <= lfsr_n;
      cnt   <= cnt_n;
      codes <= codes_n;
      valid <= valid_n;
    end
  end

  assign ready = (state == IDLE);

endmodule

// File: tb/tb_lfsr_code_gen.sv
// Directed bench for lfsr_code_gen: a STEPS=1 instance driven from a vector table and
// free-run, plus a STEPS=12 instance for the long-word, seed-load and reset-abort sequences.
module tb_lfsr_code_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1 = 1'b1, sl1 = 1'b0, req1 = 1'b0;
  logic [11:0] si1 = '0;
  logic        ready1, valid1;
  logic [11:0] codes1;

  logic        rst12 = 1'b1, sl12 = 1'b0, req12 = 1'b0;
  logic [11:0] si12 = '0;
  logic        ready12, valid12;
  logic [11:0] codes12;

  lfsr_code_gen #(.STEPS(1)) u_s1 (
    .clk(clk), .rst(rst1), .seed_load(sl1), .seed_in(si1), .req(req1),
    .ready(ready1), .valid(valid1), .codes(codes1)
  );

  lfsr_code_gen #(.STEPS(12)) u_s12 (
    .clk(clk), .rst(rst12), .seed_load(sl12), .seed_in(si12), .req(req12),
    .ready(ready12), .valid(valid12), .codes(codes12)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs are changed at the negedge; one call = one rising edge, then sample at the next negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst;
    logic        sl;
    logic [11:0] si;
    logic        req;
    logic        ev;
    logic        er;
    logic [11:0] ec;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [11:0] si,
                              input logic q, input logic ev, input logic er,
                              input logic [11:0] ec);
    vec_t v;
    v.rst = r; v.sl = s; v.si = si; v.req = q; v.ev = ev; v.er = er; v.ec = ec;
    return v;
  endfunction

  task automatic wait_valid12(input int bound, output int n);
    n = 0;
    while (valid12 !== 1'b1 && n < bound) begin
      cyc();
      n++;
    end
  endtask

  vec_t vq[$];
  bit   seen[4096];
  int   n, words, dups, guard;

  initial begin
    @(negedge clk);

    // ---------------- STEPS=1 vector table ----------------
`ifndef LFSR_CODE_GEN_DISTINCT_EN
    vq.push_back(mk(1, 0, 12'h000, 0, 0, 1, 12'h000));
    vq.push_back(mk(0, 0, 12'h000, 1, 0, 0, 12'h000));
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 1, 12'h27B));
    vq.push_back(mk(0, 0, 12'h000, 1, 0, 0, 12'h27B));
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 1, 12'h4F6));
    vq.push_back(mk(0, 0, 12'h000, 0, 0, 1, 12'h4F6));
    vq.push_back(mk(0, 1, 12'h000, 1, 0, 1, 12'h4F6));
    vq.push_back(mk(0, 0, 12'h000, 1, 0, 0, 12'h4F6));
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 1, 12'h27B));
    vq.push_back(mk(0, 1, 12'h4F6, 0, 0, 1, 12'h27B));
    vq.push_back(mk(0, 0, 12'h000, 1, 0, 0, 12'h27B));
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 1, 12'h9ED));
`else
    vq.push_back(mk(1, 0, 12'h000, 0, 0, 1, 12'h000));
    vq.push_back(mk(0, 0, 12'h000, 1, 0, 0, 12'h000));
    vq.push_back(mk(0, 0, 12'h000, 0, 0, 0, 12'h000));
    vq.push_back(mk(0, 0, 12'h000, 0, 0, 0, 12'h000));
    vq.push_back(mk(0, 0, 12'h000, 0, 0, 0, 12'h000));
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 1, 12'h3DA));
    vq.push_back(mk(0, 0, 12'h000, 0, 0, 1, 12'h3DA));
`endif
    foreach (vq[i]) begin
      rst1 = vq[i].rst; sl1 = vq[i].sl; si1 = vq[i].si; req1 = vq[i].req;
      cyc();
      check($sformatf("vec%0d valid", i), {11'd0, valid1}, {11'd0, vq[i].ev});
      check($sformatf("vec%0d ready", i), {11'd0, ready1}, {11'd0, vq[i].er});
      check($sformatf("vec%0d codes", i), codes1, vq[i].ec);
    end
    rst1 = 0; sl1 = 0; req1 = 0;

    // ---------------- STEPS=12: latency and back-to-back ----------------
    rst12 = 1; cyc(); rst12 = 0;
    req12 = 1; cyc();
    check("s12 ready after E0", {11'd0, ready12}, 12'd0);
    for (int k = 1; k <= 11; k++) begin
      cyc();
      check($sformatf("s12 ready E%0d", k), {11'd0, ready12}, 12'd0);
      check($sformatf("s12 early valid E%0d", k), {11'd0, valid12}, 12'd0);
    end
    cyc();
    check("s12 valid E12", {11'd0, valid12}, 12'd1);
    check("s12 codes E12", codes12, 12'hA11);
    check("s12 ready E12", {11'd0, ready12}, 12'd1);
    cyc();
    check("s12 b2b ready", {11'd0, ready12}, 12'd0);
    check("s12 valid pulse width", {11'd0, valid12}, 12'd0);
    check("s12 codes held", codes12, 12'hA11);
    req12 = 0;
    wait_valid12(40, n);
    check("s12 second word latency", n[11:0], 12'd12);
    req12 = 0; cyc();

    // ---------------- STEPS=12: zero seed_load mid-word ----------------
    req12 = 1; cyc(); req12 = 0;
    repeat (4) cyc();
    sl12 = 1; si12 = 12'h000; cyc(); sl12 = 0;
    check("seedload ready", {11'd0, ready12}, 12'd1);
    check("seedload valid", {11'd0, valid12}, 12'd0);
    wait_valid12(16, n);
    check("seedload aborted word silent", {11'd0, valid12}, 12'd0);
    req12 = 1; cyc(); req12 = 0;
    wait_valid12(20, n);
    check("seedload latency", n[11:0], 12'd12);
    check("seedload SEED word", codes12, 12'hA11);
    cyc();

    // ---------------- STEPS=12: reset mid-word ----------------
    req12 = 1; cyc();
    repeat (6) cyc();
    rst12 = 1; cyc(); rst12 = 0;
    check("rst codes", codes12, 12'h000);
    check("rst valid", {11'd0, valid12}, 12'd0);
    check("rst ready", {11'd0, ready12}, 12'd1);
    cyc();
    req12 = 0;
    wait_valid12(20, n);
    check("post-rst latency", n[11:0], 12'd12);
    check("post-rst word", codes12, 12'hA11);
    cyc();

`ifndef LFSR_CODE_GEN_DISTINCT_EN
    // ---------------- STEPS=1 free-run over the full period ----------------
    rst1 = 1; cyc(); rst1 = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    words = 0; dups = 0; guard = 0;
    req1 = 1;
    while (words < 4095 && guard < 12000) begin
      cyc();
      guard++;
      if (valid1 === 1'b1) begin
        if (codes1 == 12'h000 || seen[codes1]) dups++;
        seen[codes1] = 1'b1;
        words++;
      end
    end
    req1 = 0;
    check("freerun word count", words[11:0], 12'd4095);
    check("freerun repeats", dups[11:0], 12'd0);
    check("freerun wraps to SEED", codes1, 12'h13D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
